spike_shift_pipe: RTL and testbench

SPIKE_SHIFT_PIPE -- requirements
Module: spike_shift_pipe

---
 rtl/spike_shift_pkg.sv | 15 +
 rtl/spike_shift_core.sv | 43 ++++
 rtl/spike_shift_pipe.sv | 153 +++++++++++++++
 tb/tb_spike_shift_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_shift_pkg.sv
// Shared shift-code helpers for the spike shift pipeline: code width, signed shift type, code decode.
package spike_shift_pkg;

  typedef logic signed [7:0] shift_t;

  function automatic int shift_code_w(input int mag);
    return $clog2(2 * mag + 1);
  endfunction

  // Offset-binary code: code == mag means no shift.
  function automatic shift_t code_to_shift(input int code, input int mag);
    return shift_t'(code - mag);
  endfunction

endpackage

// File: rtl/spike_shift_core.sv
// Combinational single-channel spike shift from a one-hot shift select; an all-zero select marks an illegal code.
module spike_shift_core
  import spike_shift_pkg::*;
#(
  parameter int LEN = 8,
  parameter int MAX_SHIFT_MAG = 2,
  localparam int NS = 2 * MAX_SHIFT_MAG + 1
) (
  input  logic [NS-1:0]  shift_oh,
  input  logic           wrap,
  input  logic [LEN-1:0] spikes_in,
  output logic [LEN-1:0] spikes_out,
  output logic           drop,
  output logic           err
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  int            dst;
  logic [IW-1:0] idx;

  // Each input bit is scattered to its destination; bits landing outside the window are drops.
  always_comb begin
    spikes_out = '0;
    drop       = 1'b0;
    dst        = 0;
    idx        = '0;
    for (int k = 0; k < NS; k++) begin
      if (shift_oh[k]) begin
        for (int i = 0; i < LEN; i++) begin
          dst = i + int'(code_to_shift(k, MAX_SHIFT_MAG));
          if (wrap) dst = ((dst % LEN) + LEN) % LEN;
          idx = IW'(dst);
          if (dst >= 0 && dst < LEN) spikes_out[idx] = spikes_out[idx] | spikes_in[i];
          else                       drop = drop | spikes_in[i];
        end
      end
    end
  end

  assign err = ~|shift_oh;

endmodule

// File: rtl/spike_shift_pipe.sv
// Two-stage valid/ready pipe shifting NCH spike windows; latency 2, one beat per cycle, stalls hold output.
// Defining SPIKE_SHIFT_DROP_CNT_EN adds a saturating 16-bit drop_cnt of dropped spike bits.
module spike_shift_pipe
  import spike_shift_pkg::*;
#(
  parameter int LEN = 8,
  parameter int NCH = 4,
  parameter int MAX_SHIFT_MAG = 2,
  localparam int SW = shift_code_w(MAX_SHIFT_MAG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*LEN-1:0] in_spikes,
  input  logic [NCH*SW-1:0]  in_shift,
  input  logic               in_wrap,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*LEN-1:0] out_spikes,
  output logic [NCH-1:0]     out_drop,
  output logic [NCH-1:0]     out_err
`ifdef SPIKE_SHIFT_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int NS = 2 * MAX_SHIFT_MAG + 1;

  logic               s1_valid_q, s1_valid_d;
  logic [NCH*LEN-1:0] s1_spikes_q, s1_spikes_d;
  logic [NCH*NS-1:0]  s1_oh_q, s1_oh_d;
  logic               s1_wrap_q, s1_wrap_d;
  logic               s2_valid_q, s2_valid_d;
  logic [NCH*LEN-1:0] s2_spikes_q, s2_spikes_d;
  logic [NCH-1:0]     s2_drop_q, s2_drop_d;
  logic [NCH-1:0]     s2_err_q, s2_err_d;

  logic [NCH*NS-1:0]  in_oh;
  logic [NCH*LEN-1:0] core_spikes;
  logic [NCH-1:0]     core_drop;
  logic [NCH-1:0]     core_err;
  logic               s2_load, s1_advance, in_fire;

  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_load;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // Codes above 2*MAX_SHIFT_MAG decode to an all-zero select.
  always_comb begin
    in_oh = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NS; k++)
        in_oh[c*NS+k] = (in_shift[c*SW +: SW] == SW'(k));
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    spike_shift_core #(
      .LEN          (LEN),
      .MAX_SHIFT_MAG(MAX_SHIFT_MAG)
    ) u_core (
      .shift_oh  (s1_oh_q[c*NS +: NS]),
      .wrap      (s1_wrap_q),
      .spikes_in (s1_spikes_q[c*LEN +: LEN]),
      .spikes_out(core_spikes[c*LEN +: LEN]),
      .drop      (core_drop[c]),
      .err       (core_err[c])
    );
  end

  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_spikes_d = s1_spikes_q;
    s1_oh_d     = s1_oh_q;
    s1_wrap_d   = s1_wrap_q;
    if (in_fire) begin
      s1_spikes_d = in_spikes;
      s1_oh_d     = in_oh;
      s1_wrap_d   = in_wrap;
    end
    s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
    s2_spikes_d = s2_spikes_q;
    s2_drop_d   = s2_drop_q;
    s2_err_d    = s2_err_q;
    if (s1_advance) begin
      s2_spikes_d = core_spikes;
      s2_drop_d   = core_drop;
      s2_err_d    = core_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_spikes_q <= '0;
      s1_oh_q     <= '0;
      s1_wrap_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_spikes_q <= '0;
      s2_drop_q   <= '0;
      s2_err_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_spikes_q <= s1_spikes_d;
      s1_oh_q     <= s1_oh_d;
      s1_wrap_q   <= s1_wrap_d;
      s2_valid_q  <= s2_valid_d;
      s2_spikes_q <= s2_spikes_d;
      s2_drop_q   <= s2_drop_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_spikes = s2_spikes_q;
  assign out_drop   = s2_drop_q;
  assign out_err    = s2_err_q;

`ifdef SPIKE_SHIFT_DROP_CNT_EN
  logic [15:0] s2_dbits_q, s2_dbits_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] core_dbits;
  logic [16:0] cnt_sum;

  // A truncating shift is injective, so lost bits = input popcount minus output popcount.
  always_comb begin
    core_dbits = '0;
    for (int c = 0; c < NCH; c++)
      if (core_drop[c])
        core_dbits = core_dbits + 16'($countones(s1_spikes_q[c*LEN +: LEN])
                                    - $countones(core_spikes[c*LEN +: LEN]));
    s2_dbits_d = s1_advance ? core_dbits : s2_dbits_q;
    cnt_sum    = {1'b0, drop_cnt_q} + {1'b0, s2_dbits_q};
    drop_cnt_d = drop_cnt_q;
    if (s2_valid_q && out_ready) drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_dbits_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      s2_dbits_q <= s2_dbits_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_shift_pipe.sv
// Randomized and directed bench for spike_shift_pipe against a per-output-bit reference model and a scoreboard.
`timescale 1ns/1ps
module tb_spike_shift_pipe;

  localparam int LEN = 8;
  localparam int NCH = 4;
  localparam int MAG = 2;
  localparam int SW  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_wrap;
  logic [NCH*LEN-1:0] in_spikes;
  logic [NCH*SW-1:0]  in_shift;
  logic               out_valid, out_ready;
  logic [NCH*LEN-1:0] out_spikes;
  logic [NCH-1:0]     out_drop, out_err;
`ifdef SPIKE_SHIFT_DROP_CNT_EN
  logic [15:0]        drop_cnt;
`endif

  typedef struct {
    logic [NCH*LEN-1:0] spk;
    logic [NCH-1:0]     drop;
    logic [NCH-1:0]     err;
    int                 dbits;
    int                 t_in;
  } exp_t;

  exp_t               sb[$];
  int                 ntests = 0;
  int                 nfail = 0;
  int                 cyc = 0;
  int                 exp_cnt = 0;
  bit                 rand_rdy = 1'b0;
  bit                 chk_lat = 1'b0;
  bit                 held = 1'b0;
  bit                 accepted = 1'b0;
  logic [NCH*LEN-1:0] h_spk;
  logic [NCH-1:0]     h_drop, h_err;

  spike_shift_pipe #(.LEN(LEN), .NCH(NCH), .MAX_SHIFT_MAG(MAG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_spikes (in_spikes),
    .in_shift  (in_shift),
    .in_wrap   (in_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_spikes(out_spikes),
    .out_drop  (out_drop),
    .out_err   (out_err)
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output-centric reference: out[t] pulls from in[t-s], modulo LEN when wrapping.
  function automatic exp_t model(input logic [NCH*LEN-1:0] s, input logic [NCH*SW-1:0] sh,
                                 input logic w);
    exp_t e;
    int   code, sft, src, nin, nout;
    e.spk = '0; e.drop = '0; e.err = '0; e.dbits = 0; e.t_in = 0;
    for (int c = 0; c < NCH; c++) begin
      code = int'(sh[c*SW +: SW]);
      if (code > 2 * MAG) begin
        e.err[c] = 1'b1;
        continue;
      end
      sft = code - MAG;
      for (int t = 0; t < LEN; t++) begin
        src = t - sft;
        if (w) src = ((src % LEN) + LEN) % LEN;
        if (src >= 0 && src < LEN) e.spk[c*LEN+t] = s[c*LEN+src];
      end
      nin = 0; nout = 0;
      for (int t = 0; t < LEN; t++) begin
        nin  += int'(s[c*LEN+t]);
        nout += int'(e.spk[c*LEN+t]);
      end
      if (!w && nin != nout) begin
        e.drop[c] = 1'b1;
        e.dbits  += nin - nout;
      end
    end
    return e;
  endfunction

  // One clock: sample at negedge+1, update scoreboard, advance to next negedge.
  task automatic cycle();
    exp_t e;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    accepted = 1'b0;
    if (!rst) begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_spikes", out_spikes, h_spk);
        check("hold_drop", out_drop, h_drop);
        check("hold_err", out_err, h_err);
      end
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_spikes", out_spikes, e.spk);
          check("out_drop", out_drop, e.drop);
          check("out_err", out_err, e.err);
          if (chk_lat) check("latency", cyc - e.t_in, 2);
          exp_cnt = (exp_cnt + e.dbits > 65535) ? 65535 : exp_cnt + e.dbits;
        end
      end
      held = out_valid && !out_ready;
      h_spk = out_spikes; h_drop = out_drop; h_err = out_err;
      if (in_valid && in_ready) begin
        e = model(in_spikes, in_shift, in_wrap);
        e.t_in = cyc;
        sb.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      held = 1'b0;
      exp_cnt = 0;
    end
    @(negedge clk);
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    if (!rst) check("drop_cnt", drop_cnt, exp_cnt);
`endif
  endtask

  task automatic drive(input logic [NCH*LEN-1:0] s, input logic [NCH*SW-1:0] sh, input logic w);
    int n;
    n = 0;
    in_valid = 1'b1; in_spikes = s; in_shift = sh; in_wrap = w;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    check("accept_timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_spikes", out_spikes, 0);
    check("rst_out_drop", out_drop, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
  endtask

  initial begin
    logic [NCH*SW-1:0] sh;
    rst = 1'b1; in_valid = 1'b0; in_spikes = '0; in_shift = '0; in_wrap = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    check_reset_state();

    // Directed single beats, out_ready held high so latency is exact.
    chk_lat = 1'b1;
    drive(32'h0000_0002, 12'o2223, 1'b0);
    drain();
    drive(32'h0000_0080, 12'o2224, 1'b0);
    drive(32'h0000_0080, 12'o2224, 1'b1);
    drain();
    drive(32'h0000_0063, 12'o2220, 1'b1);
    drain();
    sh = 12'($urandom);
    sh[8:6] = 3'd7;
    drive($urandom, sh, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) drive($urandom, 12'($urandom), 1'($urandom_range(0, 1)));
    drain();
    chk_lat = 1'b0;

    // Ten back-to-back beats with random downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) drive($urandom, 12'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // Long random traffic with idle gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) drive($urandom, 12'($urandom), 1'($urandom_range(0, 1)));
      else cycle();
    end
    drain();

    // Reset with two beats in flight.
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drive(32'hFFFF_FFFF, 12'o0000, 1'b0);
    drain();
    out_ready = 1'b0;
    drive(32'h8181_8181, 12'o4444, 1'b0);
    drive($urandom, 12'($urandom), 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_state();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("no_stale_beat", out_valid, 0);
    end

    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) drive($urandom, 12'($urandom), 1'($urandom_range(0, 1)));
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
